// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use and branch
// hazards, data-memory wait freeze with timeout, and stall/flush counters.
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic [4:0]       exRd,
    input  logic             exMemRead,
    input  logic             exPcSrc,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexWrite,
    output logic             idexFlush,
    output logic             exmemWrite,
    output logic             memwbFlush,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_load_use;
    logic               w_mem_stall;
    logic               w_freeze;

    // x0 is never a real producer, so it cannot create a load-use hazard.
    assign w_load_use  = exMemRead && (exRd != 5'd0) &&
                         ((idUsesRs1 && (exRd == idRs1)) ||
                          (idUsesRs2 && (exRd == idRs2)));
    assign w_mem_stall = memReq && !memReady;
    assign w_freeze    = (r_state == S_HALT) || w_mem_stall;

    // Control outputs: zero-latency, priority freeze > branch > load-use.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexWrite  = 1'b1;
        idexFlush  = 1'b0;
        exmemWrite = 1'b1;
        memwbFlush = 1'b0;
        if (w_freeze) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
        end else if (exPcSrc) begin
            ifidFlush  = 1'b1;
            idexFlush  = 1'b1;
        end else if (w_load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexFlush  = 1'b1;
        end
    end

    // Memory-wait FSM with timeout into a reset-only HALT state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        r_state    <= S_HALT;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Performance counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pcWrite) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifidFlush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign memTimeout = r_timeout;
    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_hazard_unit;

    localparam int unsigned MT = 4;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rstN;
    logic [4:0]    idRs1, idRs2, exRd;
    logic          idUsesRs1, idUsesRs2, exMemRead, exPcSrc, memReq, memReady;
    logic          pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush;
    logic          exmemWrite, memwbFlush, memTimeout;
    logic [CW-1:0] stallCount, flushCount;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_halt;
    int m_run;
    bit m_timeout;
    int m_stall;
    int m_flush;

    hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rstN(rstN),
        .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exMemRead(exMemRead), .exPcSrc(exPcSrc),
        .memReq(memReq), .memReady(memReady),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexWrite(idexWrite), .idexFlush(idexFlush), .exmemWrite(exmemWrite),
        .memwbFlush(memwbFlush), .memTimeout(memTimeout),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_ctl();
        return {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
                exmemWrite, memwbFlush, memTimeout};
    endfunction

    function automatic logic [7:0] model_ctl();
        bit stall;
        bit lu;
        stall = memReq && !memReady;
        lu = exMemRead && (exRd != 0) &&
             ((idUsesRs1 && exRd == idRs1) || (idUsesRs2 && exRd == idRs2));
        if (m_halt || stall) return {7'b0000001, m_timeout};
        if (exPcSrc)         return {7'b1111110, m_timeout};
        if (lu)              return {7'b0001110, m_timeout};
        return {7'b1101010, m_timeout};
    endfunction

    function automatic logic [2*CW-1:0] model_cnt();
        return {CW'(m_stall), CW'(m_flush)};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic pcs,
                          input logic req, input logic rdy);
        idRs1 = rs1; idRs2 = rs2; idUsesRs1 = u1; idUsesRs2 = u2;
        exRd = rd; exMemRead = mr; exPcSrc = pcs; memReq = req; memReady = rdy;
        #1;
    endtask

    // Advance one clock and step the model by the rules for that cycle.
    task automatic tick();
        logic [7:0] c;
        bit stall;
        c = model_ctl();
        stall = memReq && !memReady;
        @(posedge clk);
        if (!c[7]) m_stall++;
        if (c[5])  m_flush++;
        if (!m_halt) begin
            if (stall) begin
                m_run++;
                if (m_run >= int'(MT)) begin
                    m_halt = 1'b1;
                    m_timeout = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rstN = 1'b0;
        #1;
        m_halt = 0; m_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        checks++;
        if ({memTimeout, stallCount, flushCount} !== {1'b0, CW'(0), CW'(0)}) begin
            errors++;
            $display("FAIL %s async clear: got to=%b stall=%0d flush=%0d, need 0/0/0",
                     tag, memTimeout, stallCount, flushCount);
        end
        checks++;
        if (dut_ctl() !== model_ctl()) begin
            errors++;
            $display("FAIL %s ctl in reset: got=%b need=%b", tag, dut_ctl(), model_ctl());
        end
        @(negedge clk);
        rstN = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b0;
        #12;
        do_reset("reset");
        checks++;
        if (dut_ctl() !== 8'b11010100) begin
            errors++;
            $display("FAIL reset_default: got=%b need=%b", dut_ctl(), 8'b11010100);
        end
    endtask

    task automatic test_load_use();
        do_reset("lu_rst");
        set_in(5, 9, 1, 0, 5, 1, 0, 0, 0);
        checks++;
        if (dut_ctl() !== 8'b00011100) begin
            errors++;
            $display("FAIL load_use ctl: got=%b need=%b", dut_ctl(), 8'b00011100);
        end
        tick();
        checks++;
        if (stallCount !== CW'(1)) begin
            errors++;
            $display("FAIL load_use stallCount: got=%0d need=1", stallCount);
        end
        set_in(0, 9, 1, 0, 0, 1, 0, 0, 0);
        checks++;
        if (dut_ctl() !== model_ctl()) begin
            errors++;
            $display("FAIL load_use_x0 ctl: got=%b need=%b", dut_ctl(), model_ctl());
        end
        tick();
        set_in(3, 7, 0, 1, 7, 1, 0, 0, 0);
        checks++;
        if (dut_ctl() !== model_ctl()) begin
            errors++;
            $display("FAIL load_use_rs2 ctl: got=%b need=%b", dut_ctl(), model_ctl());
        end
        tick();
        checks++;
        if ({stallCount, flushCount} !== model_cnt()) begin
            errors++;
            $display("FAIL load_use counters: got=%h need=%h", {stallCount, flushCount}, model_cnt());
        end
    endtask

    task automatic test_branch_load_use();
        do_reset("br_rst");
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0);
        checks++;
        if (dut_ctl() !== 8'b11111100) begin
            errors++;
            $display("FAIL branch_lu ctl: got=%b need=%b", dut_ctl(), 8'b11111100);
        end
        tick();
        checks++;
        if ({stallCount, flushCount} !== {CW'(0), CW'(1)}) begin
            errors++;
            $display("FAIL branch_lu counters: got stall=%0d flush=%0d need 0/1", stallCount, flushCount);
        end
    endtask

    task automatic test_mem_wait();
        do_reset("mw_rst");
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2, 1, 1, 3, 0, 0, 1, 0);
            checks++;
            if (dut_ctl() !== 8'b00000010) begin
                errors++;
                $display("FAIL mem_wait freeze c%0d: got=%b need=%b", i, dut_ctl(), 8'b00000010);
            end
            tick();
        end
        set_in(1, 2, 1, 1, 3, 0, 0, 1, 1);
        checks++;
        if (dut_ctl() !== 8'b11010100) begin
            errors++;
            $display("FAIL mem_wait release: got=%b need=%b", dut_ctl(), 8'b11010100);
        end
        tick();
        checks++;
        if (stallCount !== CW'(3)) begin
            errors++;
            $display("FAIL mem_wait stallCount: got=%0d need=3", stallCount);
        end
    endtask

    task automatic test_freeze_branch();
        do_reset("fb_rst");
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 1, (i == 2));
            checks++;
            if (dut_ctl() !== model_ctl() || ifidFlush !== (i == 2)) begin
                errors++;
                $display("FAIL freeze_branch c%0d: got=%b need=%b", i, dut_ctl(), model_ctl());
            end
            tick();
        end
        checks++;
        if ({stallCount, flushCount} !== {CW'(2), CW'(1)}) begin
            errors++;
            $display("FAIL freeze_branch counters: got stall=%0d flush=%0d need 2/1", stallCount, flushCount);
        end
    endtask

    task automatic test_timeout();
        do_reset("to_rst");
        for (int i = 0; i < int'(MT); i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            checks++;
            if (memTimeout !== 1'b0 || dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL timeout wait c%0d: got=%b need=%b", i, dut_ctl(), model_ctl());
            end
            tick();
        end
        checks++;
        if (memTimeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout flag: got=%b need=1", memTimeout);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, (i == 1), 1, 1);
            checks++;
            if (dut_ctl() !== 8'b00000011) begin
                errors++;
                $display("FAIL halt hold c%0d: got=%b need=%b", i, dut_ctl(), 8'b00000011);
            end
            tick();
        end
        checks++;
        if (stallCount !== CW'(MT + 3)) begin
            errors++;
            $display("FAIL halt stallCount: got=%0d need=%0d", stallCount, MT + 3);
        end
        do_reset("halt_rst");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_ctl() !== 8'b11010100) begin
            errors++;
            $display("FAIL post_halt run: got=%b need=%b", dut_ctl(), 8'b11010100);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset("wrap_rst");
        for (int i = 0; i < 17; i++) begin
            set_in(6, 0, 1, 0, 6, 1, 0, 0, 0);
            tick();
        end
        checks++;
        if (stallCount !== CW'(1)) begin
            errors++;
            $display("FAIL counter_wrap: got=%0d need=1", stallCount);
        end
    endtask

    task automatic test_random();
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            if (m_halt && ($urandom_range(0, 3) == 0)) begin
                do_reset("rnd_halt_rst");
            end
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), ($urandom_range(0, 4) == 0),
                   1'($urandom), ($urandom_range(0, 9) < 6));
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("FAIL random ctl c%0d: got=%b need=%b", i, dut_ctl(), model_ctl());
            end
            tick();
            checks++;
            if ({stallCount, flushCount} !== model_cnt()) begin
                errors++;
                $display("FAIL random counters c%0d: got=%h need=%h", i, {stallCount, flushCount}, model_cnt());
            end
        end
    endtask

    initial begin
        rstN = 1'b1;
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_freeze_branch();
        test_timeout();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
